// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory program loader.
//   - state_e         : loader FSM state encoding
//   - IMEM_ADDR_WIDTH : default word-address width of the instruction memory
package mips_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LOAD    = 2'd1,
        WRITE   = 2'd2,
        RELEASE = 2'd3
    } state_e;

    localparam int IMEM_ADDR_WIDTH = 8;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles four host bytes into one big-endian 32-bit word.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : drop any partial word and restart at byte 0
//   accept     : byte_in is consumed this cycle
//   byte_in    : host byte
//   word_out   : assembled word; valid together with word_done
//   word_done  : the byte being accepted completes a word
module imem_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        word_done
);

    logic [1:0]  cnt_q;
    logic [23:0] shift_q;   // bytes 0..2, byte 0 in the top lane

    // The 4th byte is merged combinationally so the caller can register the
    // full word on the same edge that accepts it.
    assign word_out  = {shift_q, byte_in};
    assign word_done = accept && (cnt_q == 2'd3);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
        end else if (accept) begin
            cnt_q   <= cnt_q + 2'd1;
            shift_q <= {shift_q[15:0], byte_in};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Program-load controller for the instruction memory. Stalls the CPU, takes a
// host byte stream, writes big-endian words to word addresses 0,1,2,... and
// finishes with a one-cycle PC reset pulse before handing the memory address
// port back to the fetch path.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   load_start, load_words   : begin a load of load_words words (RUN only)
//   load_abort               : abandon the load, partial word discarded
//   byte_valid/data/ready    : host byte handshake
//   fetch_addr               : PC byte address, passed through in RUN
//   imem_addr                : byte address to instruction memory
//   mem_we, mem_wdata        : instruction-memory write port
//   cpu_stall, cpu_pc_reset  : CPU control
//   busy                     : loader not in RUN
module imem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_start,
    input  logic [ADDR_WIDTH:0] load_words,
    input  logic                load_abort,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    output logic                byte_ready,
    input  logic [31:0]         fetch_addr,
    output logic [31:0]         imem_addr,
    output logic                mem_we,
    output logic [31:0]         mem_wdata,
    output logic                cpu_stall,
    output logic                cpu_pc_reset,
    output logic                busy
);

    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam int PAD = 32 - ADDR_WIDTH - 3;

    state_e              state_q;
    // One bit wider than the word address so a full-memory load can count
    // to 2^ADDR_WIDTH without the pointer wrapping back onto word 0.
    logic [ADDR_WIDTH:0] ptr_q, ptr_d, count_q;
    logic                mem_we_q, cpu_stall_q, cpu_pc_reset_q, busy_q;
    logic [31:0]         mem_wdata_q;

    logic                accept, word_done, pk_clear;
    logic [31:0]         word_out;

    // Abort takes precedence over a byte offered in the same cycle.
    assign byte_ready = (state_q == LOAD) && !load_abort;
    assign accept     = byte_ready && byte_valid;
    assign pk_clear   = ((state_q == RUN) && load_start) ||
                        ((state_q == LOAD) && load_abort);
    assign ptr_d      = ptr_q + 1'b1;

    assign imem_addr  = (state_q == RUN) ? fetch_addr
                                         : {{PAD{1'b0}}, ptr_q, 2'b00};

    assign mem_we       = mem_we_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_stall    = cpu_stall_q;
    assign cpu_pc_reset = cpu_pc_reset_q;
    assign busy         = busy_q;

    imem_word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (pk_clear),
        .accept    (accept),
        .byte_in   (byte_data),
        .word_out  (word_out),
        .word_done (word_done)
    );

    // Outputs are set on the transition into the state that owns them, so
    // they are registered yet line up with that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            ptr_q          <= '0;
            count_q        <= '0;
            mem_we_q       <= 1'b0;
            mem_wdata_q    <= 32'd0;
            cpu_stall_q    <= 1'b0;
            cpu_pc_reset_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            mem_we_q       <= 1'b0;
            cpu_pc_reset_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (load_start) begin
                        ptr_q       <= '0;
                        count_q     <= (load_words > MAX_WORDS) ? MAX_WORDS : load_words;
                        cpu_stall_q <= 1'b1;
                        busy_q      <= 1'b1;
                        if (load_words == '0) begin
                            state_q        <= RELEASE;
                            cpu_pc_reset_q <= 1'b1;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (load_abort) begin
                        state_q        <= RELEASE;
                        cpu_pc_reset_q <= 1'b1;
                    end else if (word_done) begin
                        state_q     <= WRITE;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= word_out;
                    end
                end
                WRITE: begin
                    ptr_q <= ptr_d;
                    // An abort seen here lets the current write finish.
                    if ((ptr_d == count_q) || load_abort) begin
                        state_q        <= RELEASE;
                        cpu_pc_reset_q <= 1'b1;
                    end else begin
                        state_q <= LOAD;
                    end
                end
                RELEASE: begin
                    state_q     <= RUN;
                    cpu_stall_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
                default: state_q <= RUN;
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program-load controller for the instruction memory of the single-cycle MIPS core. It accepts a byte stream from a host link, assembles 32-bit big-endian words, and writes them to consecutive instruction-memory word addresses starting at 0. While it does this, it holds the CPU in stall and owns the memory address port. When loading completes it pulses a PC reset and returns memory ownership to the fetch path. It sits between the host byte interface, the fetch stage (PC) and the instruction memory.

## Interface
Parameters:
- ADDR_WIDTH, 8, word-address width of instruction memory (2^ADDR_WIDTH words; 256 by default)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- load_start  in  1  one-cycle request to begin a load; sampled only in RUN
- load_words  in  ADDR_WIDTH+1  number of words to load, sampled with load_start
- load_abort  in  1  abandon the current load; a partial word is discarded
- byte_valid  in  1  host byte present
- byte_data  in  8  host byte
- byte_ready  out  1  loader accepts byte this cycle
- fetch_addr  in  32  PC byte address from the fetch stage
- imem_addr  out  32  byte address driven to instruction memory
- mem_we  out  1  instruction-memory write strobe
- mem_wdata  out  32  word to write
- cpu_stall  out  1  freeze PC/register writes
- cpu_pc_reset  out  1  one-cycle pulse forcing PC to 0
- busy  out  1  high in any state other than RUN

## Operation
States: RUN (reset state), LOAD, WRITE, RELEASE.

- **RUN**
  - imem_addr = fetch_addr.
  - cpu_stall = 0; byte_ready = 0.
  - load_start → LOAD. On entry, clear the word pointer and the byte counter, and latch the word count.
- **Word count**
  - The latched count saturates to 2^ADDR_WIDTH when load_words exceeds it.
  - If load_words = 0, load_start goes directly to RELEASE with no writes.
- **LOAD**
  - byte_ready = 1.
  - Byte accepted on byte_valid && byte_ready.
  - Byte counter 0..3. Byte 0 → bits 31:24, byte 1 → 23:16, byte 2 → 15:8, byte 3 → 7:0.
  - On acceptance of byte 3 → WRITE.
- **WRITE**
  - mem_we = 1 for exactly one cycle; byte_ready = 0.
  - imem_addr = {ptr, 2'b00}, zero-extended to 32 bits.
  - Afterwards ptr increments.
  - If the words written now equal the count → RELEASE, else → LOAD.
- **RELEASE**
  - cpu_pc_reset = 1 for one cycle, cpu_stall = 1, then → RUN.
- **cpu_stall** is 1 in LOAD, WRITE and RELEASE.
- **imem_addr** is {ptr, 2'b00} in LOAD, WRITE and RELEASE.
- **load_abort**
  - In LOAD: → RELEASE, discarding the partial word. Memory words already written stay.
  - In WRITE: the write completes, then → RELEASE.
  - Ignored in RUN and RELEASE.
- **Simultaneous events**
  - load_abort together with a byte in LOAD: abort wins and the byte is not consumed (byte_ready is forced 0 that cycle).
  - load_start outside RUN is ignored.
- **Wrap-around:** ptr cannot wrap. With count = 2^ADDR_WIDTH, the last write is at word 2^ADDR_WIDTH−1, then → RELEASE.

## Timing
- **Reset values:** state = RUN, mem_we = 0, mem_wdata = 0, cpu_stall = 0, cpu_pc_reset = 0, busy = 0, byte_ready = 0, ptr = 0, byte counter = 0.
- **Load start:** load_start at cycle t gives LOAD and cpu_stall = 1 at t+1.
- **Write latency:** the 4th byte accepted at cycle t gives mem_we = 1 at t+1, with mem_wdata and the address stable in that cycle.
- **Release:** cpu_pc_reset is high in the cycle after the final mem_we. RUN and cpu_stall = 0 follow one cycle later.
- **Throughput:** a gap-free stream needs 5 cycles per word (4 byte cycles + 1 write cycle).
- **Reset mid-operation:** reset mid-load returns to RUN with no cpu_pc_reset pulse. Partial memory contents are retained.
- **Output registration:** all outputs are registered except imem_addr and byte_ready, which are combinational from the state.

## Structure
- **Shared package (mips_pkg):** state encoding constants (RUN = 2'd0, LOAD = 2'd1, WRITE = 2'd2, RELEASE = 2'd3) and the default IMEM_ADDR_WIDTH = 8.
- **Sub-module:** one natural sub-module, imem_word_packer. It is the byte counter plus shift register, with ports clear, accept, byte_in → word_out, word_done.
- **Top level:** the FSM, pointer and address mux.
- **Instruction memory:** the top-level integration gives the instruction memory a write port driven by mem_we/imem_addr/mem_wdata.

## Test plan
- **Basic load:** reset, then load_start with load_words = 2, then bytes 20 08 00 05 8C 09 00 04 sent back-to-back.
  - mem_we at word 0 with data 0x20080005, then at word 1 with data 0x8C090004.
  - One cpu_pc_reset pulse, then RUN.
  - cpu_stall high from t+1 through the RELEASE cycle.
- **Stalled host:** byte_valid toggled every other cycle during a 1-word load of DE AD BE EF.
  - Exactly one write of 0xDEADBEEF at word 0; no byte is lost or duplicated.
- **Abort:** abort after 2 bytes of word 1 in a 3-word load.
  - Word 0 is written, word 1 is never written, the cpu_pc_reset pulse occurs, and 2 mem_we pulses are absent.
- **Zero and saturated count:**
  - load_words = 0 → RELEASE within 1 cycle, no mem_we.
  - load_words = 300 → exactly 256 writes, with the last address 0x3FC.
- **Reset mid-load:** reset in the WRITE state → all outputs return to reset values the next cycle, with no cpu_pc_reset.
- **Fetch passthrough:** in RUN, fetch_addr = 0x00000010 → imem_addr = 0x00000010. A load_start issued in LOAD is ignored.
